pwm_duty_button_conditioner: RTL

//  Upstream stage of the PWM generator. Conditions two raw push-buttons (duty up / duty down):

---
 rtl/pwm_duty_button_conditioner.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/pwm_duty_button_conditioner.sv
// Push-button front end for the PWM duty control: 2-FF sync, debounce, inc/dec arbitration and
// single-cycle step pulses. Defining PWM_BTN_AUTO_REPEAT_EN adds auto-repeat while a button is held.
`timescale 1ns/1ps
module pwm_duty_button_conditioner #(
    parameter int DEBOUNCE_CYCLES      = 250000,
    parameter int REPEAT_DELAY_CYCLES  = 25000000,
    parameter int REPEAT_PERIOD_CYCLES = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ui_increase_btn,
    input  logic ui_decrease_btn,
    output logic uo_duty_inc,
    output logic uo_duty_dec,
    output logic uo_inc_level,
    output logic uo_dec_level
);
    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY_CYCLES < 2 || REPEAT_PERIOD_CYCLES < 2) begin : g_param_check
        $error("pwm_duty_button_conditioner: all cycle parameters must be >= 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HOLD_INC = 2'd1,
        ST_HOLD_DEC = 2'd2,
        ST_LOCK     = 2'd3
    } state_t;

    // Bit 0 carries the increase button, bit 1 the decrease button.
    logic [1:0]      meta_q;
    logic [1:0]      sync_q;
    logic [1:0]      stable_q;
    logic [1:0]      stable_d;
    logic [DB_W-1:0] cnt_q [2];
    logic [DB_W-1:0] cnt_d [2];
    logic            lvl_inc_s;
    logic            lvl_dec_s;
    state_t          state_q;
    logic            inc_pulse_q;
    logic            dec_pulse_q;

    // Two-stage synchroniser for both raw buttons.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 2'b00;
            sync_q <= 2'b00;
        end else begin
            meta_q <= {ui_decrease_btn, ui_increase_btn};
            sync_q <= meta_q;
        end
    end

    // Debounce next state: a new level is accepted on its DEBOUNCE_CYCLES-th consecutive cycle.
    always_comb begin
        stable_d = stable_q;
        for (int ch = 0; ch < 2; ch++) begin
            cnt_d[ch] = '0;
            if (sync_q[ch] != stable_q[ch]) begin
                if (cnt_q[ch] == DB_LAST) begin
                    stable_d[ch] = sync_q[ch];
                end else begin
                    cnt_d[ch] = cnt_q[ch] + 1'b1;
                end
            end else begin
                cnt_d[ch] = '0;
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= 2'b00;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
        end
    end

    // The FSM looks at the levels being accepted this edge so the pulse rises together with the level.
    assign lvl_inc_s = stable_d[0];
    assign lvl_dec_s = stable_d[1];

`ifdef PWM_BTN_AUTO_REPEAT_EN
    localparam int TMR_W = ($clog2(REPEAT_DELAY_CYCLES) > $clog2(REPEAT_PERIOD_CYCLES)) ?
                           $clog2(REPEAT_DELAY_CYCLES) : $clog2(REPEAT_PERIOD_CYCLES);

    logic [TMR_W-1:0] hold_tmr_q;
    logic             rep_phase_q;
    logic             rep_fire_s;

    // Repeat fires at the end of the initial delay, then at the end of every period.
    always_comb begin
        if (rep_phase_q) begin
            rep_fire_s = (hold_tmr_q == TMR_W'(REPEAT_PERIOD_CYCLES - 1));
        end else begin
            rep_fire_s = (hold_tmr_q == TMR_W'(REPEAT_DELAY_CYCLES - 1));
        end
    end
`endif

    // Arbitration FSM with registered pulse outputs; hold timer is cleared outside the HOLD states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            inc_pulse_q <= 1'b0;
            dec_pulse_q <= 1'b0;
`ifdef PWM_BTN_AUTO_REPEAT_EN
            hold_tmr_q  <= '0;
            rep_phase_q <= 1'b0;
`endif
        end else begin
            inc_pulse_q <= 1'b0;
            dec_pulse_q <= 1'b0;
`ifdef PWM_BTN_AUTO_REPEAT_EN
            hold_tmr_q  <= '0;
            rep_phase_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (lvl_inc_s && lvl_dec_s) begin
                        state_q <= ST_LOCK;
                    end else if (lvl_inc_s) begin
                        state_q     <= ST_HOLD_INC;
                        inc_pulse_q <= 1'b1;
                    end else if (lvl_dec_s) begin
                        state_q     <= ST_HOLD_DEC;
                        dec_pulse_q <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_HOLD_INC: begin
                    if (lvl_dec_s) begin
                        state_q <= ST_LOCK;
                    end else if (!lvl_inc_s) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_HOLD_INC;
`ifdef PWM_BTN_AUTO_REPEAT_EN
                        if (rep_fire_s) begin
                            inc_pulse_q <= 1'b1;
                            rep_phase_q <= 1'b1;
                        end else begin
                            hold_tmr_q  <= hold_tmr_q + 1'b1;
                            rep_phase_q <= rep_phase_q;
                        end
`endif
                    end
                end
                ST_HOLD_DEC: begin
                    if (lvl_inc_s) begin
                        state_q <= ST_LOCK;
                    end else if (!lvl_dec_s) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_HOLD_DEC;
`ifdef PWM_BTN_AUTO_REPEAT_EN
                        if (rep_fire_s) begin
                            dec_pulse_q <= 1'b1;
                            rep_phase_q <= 1'b1;
                        end else begin
                            hold_tmr_q  <= hold_tmr_q + 1'b1;
                            rep_phase_q <= rep_phase_q;
                        end
`endif
                    end
                end
                ST_LOCK: begin
                    if (!lvl_inc_s && !lvl_dec_s) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_LOCK;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign uo_duty_inc  = inc_pulse_q;
    assign uo_duty_dec  = dec_pulse_q;
    assign uo_inc_level = stable_q[0];
    assign uo_dec_level = stable_q[1];

endmodule
